// File: rtl/s2_pack.sv
// Byte-to-word assembler: two W-bit bytes under pl_i form one 2W-bit word in a valid/accept slot.
// Word appears one edge after its 2nd byte; prdy_o drops only while a byte is held and the slot is full and not being accepted.
module s2_pack #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           pl_i,
    input  logic           clr_i,
    input  logic [W-1:0]   di_i,
    output logic           prdy_o,
    output logic [2*W-1:0] do_o,
    output logic           dov_o,
    input  logic           dor_i,
    output logic           ovf_o
);

    typedef enum logic {IDLE, HALF} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   hold_q, hold_d;
    logic [2*W-1:0] do_q, do_d;
    logic           dov_q, dov_d;
    logic           ovf_q, ovf_d;

    // Slot frees and refills on the same edge, so accept lets the next word in.
    assign prdy_o = (state_q == IDLE) || !dov_q || dor_i;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        do_d    = do_q;
        dov_d   = dov_q;
        ovf_d   = ovf_q;

        if (dov_q && dor_i) begin
            dov_d = 1'b0;
        end

        if (clr_i) begin
            state_d = IDLE;
            hold_d  = '0;
            ovf_d   = 1'b0;
        end else if (pl_i && !prdy_o) begin
            ovf_d = 1'b1;
        end else if (pl_i) begin
            if (state_q == IDLE) begin
                hold_d  = di_i;
                state_d = HALF;
            end else begin
                if (MSB_FIRST) begin
                    do_d = {hold_q, di_i};
                end else begin
                    do_d = {di_i, hold_q};
                end
                dov_d   = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
            do_q    <= '0;
            dov_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            do_q    <= do_d;
            dov_q   <= dov_d;
            ovf_q   <= ovf_d;
        end
    end

    assign do_o  = do_q;
    assign dov_o = dov_q;
    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_s2_pack.sv
// Bench for s2_pack: both byte orders driven in parallel, checked against a queue-based model.
module tb_s2_pack;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pl = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  di = '0;
    logic        dor = 1'b0;
    logic        prdy_m, prdy_l;
    logic [15:0] do_m, do_l;
    logic        dov_m, dov_l, ovf_m, ovf_l;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bytes since last flush, plus the output slot.
    logic [7:0]  pend[$];
    logic [15:0] e_do_m, e_do_l;
    logic        e_dov, e_ovf;

    s2_pack #(.W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .reset_i(reset), .pl_i(pl), .clr_i(clr), .di_i(di),
        .prdy_o(prdy_m), .do_o(do_m), .dov_o(dov_m), .dor_i(dor), .ovf_o(ovf_m)
    );

    s2_pack #(.W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .reset_i(reset), .pl_i(pl), .clr_i(clr), .di_i(di),
        .prdy_o(prdy_l), .do_o(do_l), .dov_o(dov_l), .dor_i(dor), .ovf_o(ovf_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_prdy();
        return (pend.size() == 0) || !e_dov || dor;
    endfunction

    task automatic model_reset();
        pend.delete();
        e_do_m = '0;
        e_do_l = '0;
        e_dov  = 1'b0;
        e_ovf  = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".dov_m"}, dov_m, e_dov);
        chk({tag, ".dov_l"}, dov_l, e_dov);
        chk({tag, ".do_m"},  do_m,  e_do_m);
        chk({tag, ".do_l"},  do_l,  e_do_l);
        chk({tag, ".ovf_m"}, ovf_m, e_ovf);
        chk({tag, ".ovf_l"}, ovf_l, e_ovf);
    endtask

    // One clock: drive, check prdy mid-cycle, clock, update model, check outputs.
    task automatic cyc(input logic p, input logic c, input logic [7:0] d, input logic r, input string tag);
        logic rdy, acc;
        pl = p; clr = c; di = d; dor = r;
        #1;
        rdy = model_prdy();
        chk({tag, ".prdy_m"}, prdy_m, rdy);
        chk({tag, ".prdy_l"}, prdy_l, rdy);
        @(posedge clk);
        acc = e_dov && r;
        if (acc) e_dov = 1'b0;
        if (c) begin
            pend.delete();
            e_ovf = 1'b0;
        end else if (p && !rdy) begin
            e_ovf = 1'b1;
        end else if (p) begin
            pend.push_back(d);
            if (pend.size() == 2) begin
                e_do_m = {pend[0], pend[1]};
                e_do_l = {pend[1], pend[0]};
                e_dov  = 1'b1;
                pend.delete();
            end
        end
        #1;
        check_outs(tag);
    endtask

    // Assert reset between edges and confirm it clears the slot without a clock.
    task automatic async_reset(input string tag);
        #3;
        reset = 1'b0;
        pl = 1'b1;
        #1;
        model_reset();
        check_outs(tag);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_outs("rst");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic assembly and consumption.
        cyc(1, 0, 8'h0A, 0, "t1a");
        cyc(1, 0, 8'hC5, 0, "t1b");
        chk("t1.word", do_m, 32'h0AC5);
        chk("t2.word", do_l, 32'hC50A);
        cyc(0, 0, 8'h00, 1, "t1c");
        chk("t1.kept", do_m, 32'h0AC5);

        // Overflow while slot full, then accept with refill on the same edge.
        cyc(1, 0, 8'h11, 0, "t3a");
        cyc(1, 0, 8'h22, 0, "t3b");
        cyc(1, 0, 8'h33, 0, "t3c");
        cyc(1, 0, 8'h44, 0, "t3d");
        chk("t3.ovf", ovf_m, 32'h1);
        chk("t3.hold", do_m, 32'h1122);
        cyc(1, 0, 8'h44, 1, "t3e");
        chk("t3.new", do_m, 32'h3344);
        cyc(0, 0, 8'h00, 1, "t3f");

        // clr flushes a partial word, clears ovf, and wins over pl.
        cyc(1, 1, 8'h00, 0, "t5z");
        cyc(1, 0, 8'hAB, 0, "t5a");
        cyc(1, 1, 8'hCD, 0, "t5b");
        cyc(1, 0, 8'h12, 0, "t5c");
        cyc(1, 0, 8'h34, 0, "t5d");
        chk("t5.word", do_m, 32'h1234);
        cyc(1, 0, 8'h55, 0, "t5e");
        cyc(1, 0, 8'h66, 0, "t5f");
        chk("t5.ovf", ovf_m, 32'h1);
        cyc(0, 1, 8'h00, 1, "t5g");
        chk("t5.ovfclr", ovf_m, 32'h0);

        // Streaming with constant accept.
        for (int i = 1; i <= 6; i++) cyc(1, 0, 8'(i), 1, "t4");
        chk("t4.last", do_m, 32'h0506);
        chk("t4.ovf", ovf_m, 32'h0);

        // Async reset while half-full with a valid word.
        cyc(1, 0, 8'h77, 0, "t6a");
        cyc(1, 0, 8'h88, 0, "t6b");
        cyc(1, 0, 8'h99, 0, "t6c");
        async_reset("t6rst");
        cyc(1, 0, 8'hDE, 0, "t6d");
        cyc(1, 0, 8'hAD, 0, "t6e");
        chk("t6.word", do_m, 32'hDEAD);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd.rst");
            end else begin
                cyc(1'($urandom_range(0, 99) < 70),
                    1'($urandom_range(0, 99) < 5),
                    8'($urandom),
                    1'($urandom_range(0, 99) < 50),
                    "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
